class_hv_updater: RTL
=====================

Name: class_hv_updater

Overview:
- Sequencer that drives the class bundler and owns read-modify-write of the class hypervector memory.
- Training: streams one encoded query HV chunk by chunk, reads the matching stored class chunk, presents both to the bundler, and writes the bundler sum back.
- Binarization: sweeps every class chunk, thresholds each dimension, and writes the binarized value back through the bundler in pass-through mode.
- Sits between the encoder output stream and the class HV memory.

Parameters:
- DIMS_PER_CC, 1024, dimensions per chunk (per cycle).
- BITWIDTH_PER_DIM, 9, unsigned counter width per dimension.
- NUM_CHUNKS, 10, chunks per hypervector.
- NUM_CLASSES, 26, class HVs in memory.
- ADDR_W, $clog2(NUM_CLASSES*NUM_CHUNKS), memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start_train  in  1  one-cycle request to bundle one HV into class train_label.
- train_label  in  $clog2(NUM_CLASSES)  target class; sampled with start_train.
- start_binarize  in  1  one-cycle request to binarize all class HVs.
- threshold  in  BITWIDTH_PER_DIM  binarize threshold; sampled with start_binarize.
- in_valid  in  1  input chunk valid.
- in_ready  out  1  input chunk accepted.
- in_chunk  in  DIMS_PER_CC  binary encoded HV chunk.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  DIMS_PER_CC*BITWIDTH_PER_DIM  read data, valid 1 cycle after mem_rd_en.
- mem_wr_en  out  1  memory write strobe.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  DIMS_PER_CC*BITWIDTH_PER_DIM  write data.
- binarizing_class_hvs  out  1  bundler mode.
- input_hv_chunk  out  DIMS_PER_CC  bundler input chunk.
- stored_hv_chunk  out  DIMS_PER_CC*BITWIDTH_PER_DIM  bundler stored chunk (= mem_rd_data).
- sum  in  DIMS_PER_CC*BITWIDTH_PER_DIM  bundler result.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when an operation completes.
- label_err  out  1  one-cycle pulse when start_train is rejected because train_label >= NUM_CLASSES.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Chunk and class counters 0.
  - Memory contents are not touched.
- Addressing: address = class*NUM_CHUNKS + chunk.
- FSM states: IDLE, TR_RD, TR_WB, BIN_RD, BIN_WB, DONE.
- IDLE:
  - start_train with a valid label: latch the label, chunk=0, go to TR_RD.
  - start_train with label >= NUM_CLASSES: pulse label_err, stay in IDLE.
  - start_binarize: latch threshold, class=chunk=0, go to BIN_RD.
  - Both starts in the same cycle: train wins; start_binarize is dropped.
  - Starts arriving while busy are ignored.
- TR_RD:
  - Wait for in_valid.
  - When in_valid is high: assert mem_rd_en, capture in_chunk into a register, assert in_ready for exactly this cycle, go to TR_WB.
- TR_WB:
  - mem_rd_data is valid this cycle.
  - Drive binarizing_class_hvs=0, input_hv_chunk=captured chunk, stored_hv_chunk=mem_rd_data.
  - Write: mem_wr_en=1, mem_wr_addr=same address, mem_wr_data=sum.
  - If chunk==NUM_CHUNKS-1, go to DONE; else chunk++ and go to TR_RD.
- Training throughput: 2 cycles per chunk minimum; in_valid deassertion stalls in TR_RD indefinitely.
- BIN_RD: assert mem_rd_en, go to BIN_WB.
- BIN_WB:
  - Per dimension: bit[i] = (mem_rd_data[i] >= threshold).
  - Drive input_hv_chunk=bits, binarizing_class_hvs=1, stored_hv_chunk=mem_rd_data.
  - Write sum back: each dimension becomes zero-extended 0/1.
  - Advance chunk, then class; after class NUM_CLASSES-1 / chunk NUM_CHUNKS-1, go to DONE.
- DONE: pulse done for 1 cycle, return to IDLE.
- Arithmetic:
  - Bundler addition wraps modulo 2^BITWIDTH_PER_DIM unless SATURATE_EN is defined.
  - Threshold compare is unsigned.
- Bundler inputs outside TR_WB/BIN_WB: binarizing_class_hvs=0, input_hv_chunk=0.
- Reset mid-operation: FSM returns to IDLE immediately, no further memory writes. The partially updated class HV stays as-is; software retrains it.

Optional Feature:
- Macro: CLASS_HV_SATURATE_EN.
- Defined: in TR_WB, any dimension where mem_rd_data[i] == 2^BITWIDTH_PER_DIM-1 and in_chunk bit is 1 writes the all-ones value instead of sum[i].
- Undefined: sum is written unmodified, so 511+1 wraps to 0.

Decomposition:
- Package hdc_pkg holds:
  - DIMS_PER_CC, BITWIDTH_PER_DIM, NUM_CHUNKS, NUM_CLASSES.
  - Derived widths ADDR_W and LABEL_W.
  - Typedef chunk_t (packed [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0]).
  - FSM state enum upd_state_e.
- One sub-module is natural: chunk_binarizer, the combinational per-dimension threshold compare.

Test Plan:
- Train, label 3: memory cleared, 10 all-ones chunks with in_valid held high → addresses 30..39 read then written, every dimension = 1, done pulses at cycle 21 after start, in_ready high 10 times.
- Stall: in_valid low for 5 cycles between chunks 4 and 5 → no memory access during the stall, FSM held in TR_RD, final data correct.
- Label error: start_train with train_label=26 → label_err pulses once, busy stays 0, no memory strobes.
- Binarize, threshold=5: class 0 chunk 0 dims = {4,5,6} → written {0,1,1}; 260 write strobes total; done once.
- Wrap/saturate: dim = 511, input bit 1 → writes 0 without the macro, 511 with CLASS_HV_SATURATE_EN.
- Reset asserted in TR_WB of chunk 2 → all outputs 0 immediately, no write to chunk 3; a simultaneous start_train + start_binarize afterwards runs train only.

Source files
------------

// File: rtl/hdc_pkg.sv
// Shared parameters, types and helpers for the class hypervector update path.
// The optional saturating-add feature is selected with `define CLASS_HV_SATURATE_EN.
package hdc_pkg;

    localparam int DIMS_PER_CC      = 1024;
    localparam int BITWIDTH_PER_DIM = 9;
    localparam int NUM_CHUNKS       = 10;
    localparam int NUM_CLASSES      = 26;

    localparam int ADDR_W  = $clog2(NUM_CLASSES * NUM_CHUNKS);
    localparam int LABEL_W = $clog2(NUM_CLASSES);
    localparam int CHUNK_W = $clog2(NUM_CHUNKS);

    // One memory word: DIMS_PER_CC unsigned counters, dimension i at bits [i*BW +: BW].
    typedef logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0] chunk_t;
    typedef logic [DIMS_PER_CC-1:0]                       bits_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TR_RD  = 3'd1,
        TR_WB  = 3'd2,
        BIN_RD = 3'd3,
        BIN_WB = 3'd4,
        DONE   = 3'd5
    } upd_state_e;

    // Memory word address of a given chunk of a given class HV.
    function automatic logic [ADDR_W-1:0] chunk_addr(input logic [LABEL_W-1:0] cls,
                                                     input logic [CHUNK_W-1:0] chk);
        int unsigned full;
        full = 32'(cls) * NUM_CHUNKS + 32'(chk);
        return full[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/class_hv_updater_binarizer.sv
// Per-dimension unsigned threshold compare used during class HV binarization.
module chunk_binarizer
    import hdc_pkg::*;
(
    input  chunk_t                        data_i,
    input  logic [BITWIDTH_PER_DIM-1:0]   threshold_i,
    output bits_t                         bits_o
);

    // Each dimension becomes 1 when its counter reaches the threshold.
    always_comb begin
        bits_o = '0;
        for (int i = 0; i < DIMS_PER_CC; i++) begin
            bits_o[i] = (data_i[i] >= threshold_i);
        end
    end

endmodule

// File: rtl/class_hv_updater.sv
// Sequencer for read-modify-write of the class HV memory through the bundler.
// Training adds one streamed query HV into a class; binarization thresholds
// every stored class chunk and writes back 0/1 counters.
// Build option: `define CLASS_HV_SATURATE_EN to clamp counters at all-ones
// during training instead of wrapping.
//
// Input handshake: a chunk transfers on a cycle where in_valid and in_ready
// are both high; in_ready is only raised in TR_RD while in_valid is high, and
// the producer must hold in_chunk stable while in_valid is high.
module class_hv_updater
    import hdc_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start_train,
    input  logic [LABEL_W-1:0]                        train_label,
    input  logic                                      start_binarize,
    input  logic [BITWIDTH_PER_DIM-1:0]               threshold,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [DIMS_PER_CC-1:0]                    in_chunk,
    output logic                                      mem_rd_en,
    output logic [ADDR_W-1:0]                         mem_rd_addr,
    input  logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0]   mem_rd_data,
    output logic                                      mem_wr_en,
    output logic [ADDR_W-1:0]                         mem_wr_addr,
    output logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0]   mem_wr_data,
    output logic                                      binarizing_class_hvs,
    output logic [DIMS_PER_CC-1:0]                    input_hv_chunk,
    output logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0]   stored_hv_chunk,
    input  logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0]   sum,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      label_err
);

    localparam logic [LABEL_W-1:0] LAST_CLASS = LABEL_W'(NUM_CLASSES - 1);
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

    upd_state_e                    state_q;
    logic [LABEL_W-1:0]            class_q;
    logic [CHUNK_W-1:0]            chunk_q;
    logic [BITWIDTH_PER_DIM-1:0]   thresh_q;
    logic [DIMS_PER_CC-1:0]        in_chunk_q;
    logic                          label_err_q;

    logic [ADDR_W-1:0]             cur_addr;
    chunk_t                        rd_chunk;
    chunk_t                        sum_chunk;
    chunk_t                        train_wr_data;
    bits_t                         bin_bits;

    assign cur_addr  = chunk_addr(class_q, chunk_q);
    assign rd_chunk  = mem_rd_data;
    assign sum_chunk = sum;

    chunk_binarizer u_binarizer (
        .data_i      (rd_chunk),
        .threshold_i (thresh_q),
        .bits_o      (bin_bits)
    );

`ifdef CLASS_HV_SATURATE_EN
    // A counter already at all-ones that receives a 1 stays at all-ones.
    always_comb begin
        train_wr_data = sum_chunk;
        for (int i = 0; i < DIMS_PER_CC; i++) begin
            if ((rd_chunk[i] == '1) && in_chunk_q[i]) begin
                train_wr_data[i] = '1;
            end
        end
    end
`else
    assign train_wr_data = sum_chunk;
`endif

    // Sequencer: start arbitration, chunk/class walk, label error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            class_q     <= '0;
            chunk_q     <= '0;
            thresh_q    <= '0;
            in_chunk_q  <= '0;
            label_err_q <= 1'b0;
        end else begin
            label_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_train) begin
                        // Training wins over a simultaneous binarize request.
                        if (train_label <= LAST_CLASS) begin
                            class_q <= train_label;
                            chunk_q <= '0;
                            state_q <= TR_RD;
                        end else begin
                            label_err_q <= 1'b1;
                        end
                    end else if (start_binarize) begin
                        thresh_q <= threshold;
                        class_q  <= '0;
                        chunk_q  <= '0;
                        state_q  <= BIN_RD;
                    end
                end
                TR_RD: begin
                    if (in_valid) begin
                        in_chunk_q <= in_chunk;
                        state_q    <= TR_WB;
                    end
                end
                TR_WB: begin
                    if (chunk_q == LAST_CHUNK) begin
                        state_q <= DONE;
                    end else begin
                        chunk_q <= chunk_q + 1'b1;
                        state_q <= TR_RD;
                    end
                end
                BIN_RD: begin
                    state_q <= BIN_WB;
                end
                BIN_WB: begin
                    if (chunk_q == LAST_CHUNK) begin
                        chunk_q <= '0;
                        if (class_q == LAST_CLASS) begin
                            state_q <= DONE;
                        end else begin
                            class_q <= class_q + 1'b1;
                            state_q <= BIN_RD;
                        end
                    end else begin
                        chunk_q <= chunk_q + 1'b1;
                        state_q <= BIN_RD;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output decode from the current state; everything is 0 in IDLE.
    always_comb begin
        in_ready             = 1'b0;
        mem_rd_en            = 1'b0;
        mem_rd_addr          = '0;
        mem_wr_en            = 1'b0;
        mem_wr_addr          = '0;
        mem_wr_data          = '0;
        binarizing_class_hvs = 1'b0;
        input_hv_chunk       = '0;
        stored_hv_chunk      = '0;
        done                 = 1'b0;
        unique case (state_q)
            TR_RD: begin
                if (in_valid) begin
                    in_ready    = 1'b1;
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = cur_addr;
                end
            end
            TR_WB: begin
                input_hv_chunk  = in_chunk_q;
                stored_hv_chunk = mem_rd_data;
                mem_wr_en       = 1'b1;
                mem_wr_addr     = cur_addr;
                mem_wr_data     = train_wr_data;
            end
            BIN_RD: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = cur_addr;
            end
            BIN_WB: begin
                binarizing_class_hvs = 1'b1;
                input_hv_chunk       = bin_bits;
                stored_hv_chunk      = mem_rd_data;
                mem_wr_en            = 1'b1;
                mem_wr_addr          = cur_addr;
                mem_wr_data          = sum;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign label_err = label_err_q;

endmodule
